// File: rtl/result_serializer.sv
// ---------------------------------------------------------------------------
// result_serializer
//
// Captures WIDTH parallel compressor result bits on a capture strobe. It then
// streams them out LSB-first over a 1-bit valid/ready serial interface.
//
// Optional feature macro: RESULT_SERIALIZER_SIG_EN
//   Defined   -> sig carries a running CRC-16/CCITT signature (MSB-first
//                register, poly 16'h1021, seed 16'hFFFF). Every transferred
//                bit is folded in.
//   Undefined -> no signature logic is built and sig is tied to 16'h0000.
//
// Parameters:
//   WIDTH       number of result bits captured per word (>= 2)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   capture     request to load res into the shift register
//   res         compressor result word, bit i = compressor dst i
//   dout        current serial bit
//   dout_valid  dout holds a valid bit
//   dout_ready  consumer accepts dout this cycle
//   last        current bit is bit WIDTH-1 of the word
//   busy        word in flight
//   overrun     sticky flag: a capture was dropped
//   sig         CRC-16 signature (or 16'h0000 when the feature is off)
// ---------------------------------------------------------------------------
module result_serializer #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] res,
    output logic             dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             last,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      sig
);

    localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             overrun_nxt;
    logic             beat;
    logic             final_beat;

    // A beat is a transfer. dout_valid is exactly "state is SHIFT".
    assign beat       = (state == SHIFT) && dout_ready;
    assign final_beat = beat && (cnt == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            sreg    <= sreg_nxt;
            cnt     <= cnt_nxt;
            overrun <= overrun_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        sreg_nxt    = sreg;
        cnt_nxt     = cnt;
        overrun_nxt = overrun;

        case (state)
            IDLE: begin
                if (capture) begin
                    sreg_nxt  = res;
                    cnt_nxt   = CNT_MAX;
                    state_nxt = SHIFT;
                end
            end

            SHIFT: begin
                if (final_beat) begin
                    // A capture on the final beat chains the next word
                    // with no gap in dout_valid. It is not an overrun.
                    if (capture) begin
                        sreg_nxt = res;
                        cnt_nxt  = CNT_MAX;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (beat) begin
                        sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
                        cnt_nxt  = cnt - CW'(1);
                    end
                    // Any other capture while a word is in flight is lost.
                    if (capture) begin
                        overrun_nxt = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from registers only.
    // ------------------------------------------------------------------
    // sreg is not cleared after the final beat, so gate dout with the state.
    assign dout       = (state == SHIFT) && sreg[0];
    assign dout_valid = (state == SHIFT);
    assign busy       = (state == SHIFT);
    assign last       = (state == SHIFT) && (cnt == '0);

    // ------------------------------------------------------------------
    // Optional running signature
    // ------------------------------------------------------------------
`ifdef RESULT_SERIALIZER_SIG_EN
    logic [15:0] sig_q;
    logic        sig_fb;

    assign sig_fb = dout ^ sig_q[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 16'hFFFF;
        end else if (beat) begin
            sig_q <= {sig_q[14:0], 1'b0} ^ (sig_fb ? 16'h1021 : 16'h0000);
        end
    end

    assign sig = sig_q;
`else
    assign sig = 16'h0000;
`endif

endmodule
